pipe_interlock: RTL and testbench
=================================

PIPE_INTERLOCK -- requirements
Module: pipe_interlock

Interface
REQ-001 Parameter REG_AW, default 3: register-address width; register 0 is hard-wired zero.
REQ-002 Parameter NUM_FWD, default 3: forwarding source stages tracked (1=EX, 2=MEM, 3=WB); range 1..7.
REQ-003 Parameter LOAD_LAT, default 1: cycles after entering EX before a load result is forwardable; range 1..NUM_FWD-1.
REQ-004 Parameter CNT_W, default 16: stall-statistics counter width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 id_valid  input  1  decode stage holds a real instruction.
REQ-008 id_rs1, id_rs2  input  REG_AW each  decode source registers.
REQ-009 id_use_rs1, id_use_rs2  input  1 each  source actually read.
REQ-010 id_rd  input  REG_AW  decode destination register.
REQ-011 id_regwr  input  1  decode instruction writes id_rd.
REQ-012 id_memrd  input  1  decode instruction is a load (word or byte).
REQ-013 flush  input  1  taken branch/jump/call/ret kill from PC control.
REQ-014 hold  input  1  external freeze (memory wait); whole tracker frozen.
REQ-015 fwd_a, fwd_b  output  clog2(NUM_FWD+1)  0 = register file, k = stage k.
REQ-016 stall  output  1  freeze IF/ID, inject bubble into EX.
REQ-017 stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-018 Tracker SHALL hold NUM_FWD entries s[1..NUM_FWD], each {v, rd, wr, rdy} with rdy of width clog2(LOAD_LAT+1).
REQ-019 When hold=0, each cycle s[k+1] SHALL load s[k] with rdy decremented, saturating at 0; s[NUM_FWD] contents are discarded.
REQ-020 When hold=0, s[1] SHALL load {1, id_rd, id_regwr, id_memrd ? LOAD_LAT : 0} iff id_valid & !stall & !flush, else a bubble (v=0).
REQ-021 When hold=1, all entries and stall_count SHALL keep their values; fwd/stall outputs still evaluate from current state.
REQ-022 Source match for rsX SHALL require id_use_rsX, rsX != 0, s[k].v, s[k].wr, s[k].rd == rsX.
REQ-023 The matching entry with the smallest k SHALL win (youngest producer); no match gives fwd=0.
REQ-024 If the winning entry has rdy == 0, fwdX SHALL equal k; if rdy != 0, stall SHALL assert and fwdX SHALL be 0.
REQ-025 stall SHALL be combinational (zero latency) from ID inputs and tracker state, and be the OR over both sources.
REQ-026 stall SHALL be forced 0 when flush=1 or id_valid=0.
REQ-027 A load producer with LOAD_LAT=L SHALL cause exactly L stall cycles to a dependent consumer issued immediately behind it, then forward from stage L+1.
REQ-028 stall_count SHALL increment by 1 on each cycle with stall=1 and hold=0, saturating at 2^CNT_W-1 (no wrap).
REQ-029 flush and stall in the same cycle: flush SHALL win (bubble into s[1], stall=0).
REQ-030 rs1 == rs2 SHALL produce identical fwd_a and fwd_b.
REQ-031 Instructions with id_regwr=0 (store, branch, jump) SHALL enter tracker with wr=0 and never be forwarded from.

Reset
REQ-032 While rst_n=0 at a clock edge, every s[k].v, rdy and stall_count SHALL clear to 0; outputs then read fwd_a=fwd_b=0, stall=0.
REQ-033 Reset SHALL override hold and flush; a load in flight when reset is asserted SHALL not cause any stall after reset.

Structure
REQ-034 Shared package SHALL hold the forward-select encoding constants (FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3) and the tracker entry typedef.
REQ-035 One sub-module, pipe_src_match, SHALL implement per-source priority match and forward/stall decision; instantiated twice.

Verification
REQ-036 Defaults; ADD r1 then ADD r2,r1,r3 back-to-back -> fwd_a=1, stall=0.
REQ-037 Defaults; LW r1 then ADD r2,r1,r1 -> one cycle stall=1, fwd_a=fwd_b=0; next cycle fwd_a=fwd_b=2; stall_count=1.
REQ-038 LOAD_LAT=2, NUM_FWD=4; LW r4 then SUB r5,r4,r6 -> stall two cycles, then fwd_a=3.
REQ-039 ADD r1, ADD r1, then AND r2,r1,r1 -> fwd selects stage 1 (youngest), not 2; source r0 anywhere -> fwd=0.
REQ-040 LW r1 with dependent in ID, flush=1 same cycle -> stall=0, s[1] bubble; hold=1 for 3 cycles mid-stall -> stall_count unchanged, stall persists.
REQ-041 rst_n=0 one cycle with LW in s[1] -> after release stall=0, fwd=0, stall_count=0.

Source files
------------

// File: rtl/pipe_interlock_pkg.sv
// Shared types and constants for the pipeline interlock / forwarding unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_interlock_pkg;

  // Forward-select encoding: 0 = register file, k = tracker stage k.
  localparam int unsigned FWD_RF  = 0;
  localparam int unsigned FWD_EX  = 1;
  localparam int unsigned FWD_MEM = 2;
  localparam int unsigned FWD_WB  = 3;

  // Tracker fields are sized for the largest legal configuration so one
  // typedef serves every parameterisation. REG_AW may be at most
  // TRK_AW_MAX. NUM_FWD is at most 7, so LOAD_LAT is at most 6, which
  // fits in 3 bits. Narrower instances zero-extend into these fields.
  localparam int unsigned TRK_AW_MAX = 8;
  localparam int unsigned TRK_RDY_W  = 3;

  typedef struct packed {
    logic                  v;    // slot holds a real instruction
    logic [TRK_AW_MAX-1:0] rd;   // destination register (zero-extended)
    logic                  wr;   // instruction writes rd
    logic [TRK_RDY_W-1:0]  rdy;  // cycles until result is forwardable
  } trk_entry_t;

endpackage

// File: rtl/pipe_src_match.sv
// Per-source priority match over the tracker: picks the youngest producer of rs.
// Latency: purely combinational.
// Backpressure: none; o_busy tells the top a matching producer is not ready yet.
//
// Ports:
//   i_use  - source is actually read by the decode instruction
//   i_rs   - source register address
//   i_trk  - tracker entries, index 1 = youngest (EX)
//   o_fwd  - forward select, FWD_RF when no usable match
//   o_busy - youngest matching producer still has rdy != 0
module pipe_src_match
  import pipe_interlock_pkg::*;
#(
  parameter int REG_AW  = 3,
  parameter int NUM_FWD = 3,
  parameter int FWD_W   = 2
) (
  input  logic                     i_use,
  input  logic [REG_AW-1:0]        i_rs,
  input  trk_entry_t [NUM_FWD:1]   i_trk,
  output logic [FWD_W-1:0]         o_fwd,
  output logic                     o_busy
);

  logic             w_found;
  logic             w_busy;
  logic [FWD_W-1:0] w_sel;

  always_comb begin
    w_found = 1'b0;
    w_busy  = 1'b0;
    w_sel   = '0;
    // Scan from the youngest stage; the first hit locks the result.
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (!w_found && i_trk[k].v && i_trk[k].wr &&
          (i_trk[k].rd == TRK_AW_MAX'(i_rs))) begin
        w_found = 1'b1;
        w_sel   = FWD_W'(k);
        w_busy  = (i_trk[k].rdy != '0);
      end
    end
    // r0 is hard-wired zero and unread sources never depend on anything.
    if (!i_use || (i_rs == '0)) begin
      w_found = 1'b0;
      w_busy  = 1'b0;
    end
  end

  assign o_fwd  = (w_found && !w_busy) ? w_sel : FWD_W'(FWD_RF);
  assign o_busy = w_found && w_busy;

endmodule

// File: rtl/pipe_interlock.sv
// Load-use interlock and forwarding-select unit for an in-order pipeline.
// Latency: fwd_a/fwd_b/stall combinational from ID inputs and tracker state.
// Backpressure: stall freezes IF/ID and inserts a bubble; hold freezes the tracker.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   id_valid              - decode stage holds a real instruction
//   id_rs1/id_rs2         - decode source registers, id_use_rs1/2 qualify them
//   id_rd/id_regwr        - decode destination and its write enable
//   id_memrd              - decode instruction is a load
//   flush                 - kill from PC control, wins over stall
//   hold                  - external freeze of tracker and counter
//   fwd_a/fwd_b           - forward select per source (0 = register file)
//   stall                 - load-use interlock request
//   stall_count           - saturating count of non-held stall cycles
module pipe_interlock
  import pipe_interlock_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int FWD_W   = $clog2(NUM_FWD + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwr,
  input  logic              id_memrd,
  input  logic              flush,
  input  logic              hold,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  trk_entry_t [NUM_FWD:1] r_trk;
  logic [CNT_W-1:0]       r_stall_cnt;
  trk_entry_t             w_new;
  logic                   w_busy_a;
  logic                   w_busy_b;
  logic                   w_stall;

  pipe_src_match #(
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD),
    .FWD_W   (FWD_W)
  ) u_match_a (
    .i_use  (id_use_rs1),
    .i_rs   (id_rs1),
    .i_trk  (r_trk),
    .o_fwd  (fwd_a),
    .o_busy (w_busy_a)
  );

  pipe_src_match #(
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD),
    .FWD_W   (FWD_W)
  ) u_match_b (
    .i_use  (id_use_rs2),
    .i_rs   (id_rs2),
    .i_trk  (r_trk),
    .o_fwd  (fwd_b),
    .o_busy (w_busy_b)
  );

  // A killed or empty decode slot has nothing to wait for.
  assign w_stall     = id_valid & ~flush & (w_busy_a | w_busy_b);
  assign stall       = w_stall;
  assign stall_count = r_stall_cnt;

  // Entry presented to stage 1: the decode instruction if it issues,
  // otherwise a bubble. Loads start with LOAD_LAT cycles to go.
  always_comb begin
    w_new = '0;
    if (id_valid && !w_stall && !flush) begin
      w_new.v   = 1'b1;
      w_new.rd  = TRK_AW_MAX'(id_rd);
      w_new.wr  = id_regwr;
      w_new.rdy = id_memrd ? TRK_RDY_W'(LOAD_LAT) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trk       <= '0;
      r_stall_cnt <= '0;
    end else if (!hold) begin
      r_trk[1] <= w_new;
      // Age every entry by one stage; readiness counts down to zero.
      for (int k = 2; k <= NUM_FWD; k++) begin
        r_trk[k] <= r_trk[k-1];
        if (r_trk[k-1].rdy != '0) begin
          r_trk[k].rdy <= r_trk[k-1].rdy - 1'b1;
        end
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_interlock.sv
// Bench for pipe_interlock: directed table, hand sequences and random traffic.
// Latency: checks combinational outputs each cycle at the falling edge.
// Backpressure: two configurations share stimulus; a model tracks each.
module tb_pipe_interlock;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_valid, id_use_rs1, id_use_rs2, id_regwr, id_memrd, flush, hold;
  logic [2:0] id_rs1, id_rs2, id_rd;

  logic [1:0]  fa1, fb1;
  logic        st1;
  logic [15:0] cnt1;
  logic [2:0]  fa2, fb2;
  logic        st2;
  logic [2:0]  cnt2;

  pipe_interlock u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwr(id_regwr), .id_memrd(id_memrd),
    .flush(flush), .hold(hold),
    .fwd_a(fa1), .fwd_b(fb1), .stall(st1), .stall_count(cnt1)
  );

  pipe_interlock #(.REG_AW(3), .NUM_FWD(4), .LOAD_LAT(2), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwr(id_regwr), .id_memrd(id_memrd),
    .flush(flush), .hold(hold),
    .fwd_a(fa2), .fwd_b(fb2), .stall(st2), .stall_count(cnt2)
  );

  // Reference model: a history of issued instructions, newest at index 1.
  // A load at age k is usable iff k > LOAD_LAT; anything else is usable at once.
  typedef struct { bit v; int rd; bit wr; bit ld; } mrec_t;
  mrec_t h [2][8];
  int    mcnt [2];
  int    cfg_n [2]   = '{3, 4};
  int    cfg_l [2]   = '{1, 2};
  int    cfg_max [2] = '{65535, 7};
  bit    es [2];

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string name, int idx, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
    end
  endfunction

  // -1 = producer found but not ready, otherwise forward stage (0 = RF).
  function automatic int msrc(int c, bit u, int rs);
    if (!u || rs == 0) return 0;
    for (int k = 1; k <= cfg_n[c]; k++) begin
      if (h[c][k].v && h[c][k].wr && h[c][k].rd == rs)
        return (h[c][k].ld && k <= cfg_l[c]) ? -1 : k;
    end
    return 0;
  endfunction

  task automatic mstep(int c);
    if (!rst_n) begin
      for (int k = 1; k < 8; k++) h[c][k] = '{0, 0, 0, 0};
      mcnt[c] = 0;
    end else if (!hold) begin
      if (es[c] && mcnt[c] < cfg_max[c]) mcnt[c]++;
      for (int k = cfg_n[c]; k >= 2; k--) h[c][k] = h[c][k-1];
      h[c][1] = '{0, 0, 0, 0};
      if (id_valid && !es[c] && !flush) begin
        h[c][1].v  = 1'b1;
        h[c][1].rd = int'(id_rd);
        h[c][1].wr = id_regwr;
        h[c][1].ld = id_memrd;
      end
    end
  endtask

  // Compare both DUTs to the model at the falling edge.
  task automatic settle();
    int a, b, ea, eb;
    bit est;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      a   = msrc(c, id_use_rs1, int'(id_rs1));
      b   = msrc(c, id_use_rs2, int'(id_rs2));
      ea  = (a < 0) ? 0 : a;
      eb  = (b < 0) ? 0 : b;
      est = id_valid && !flush && (a < 0 || b < 0);
      es[c] = est;
      if (c == 0) begin
        chk("mdl_fwd_a", c, int'(fa1), ea);
        chk("mdl_fwd_b", c, int'(fb1), eb);
        chk("mdl_stall", c, int'(st1), int'(est));
        chk("mdl_stall_count", c, int'(cnt1), mcnt[c]);
      end else begin
        chk("mdl_fwd_a", c, int'(fa2), ea);
        chk("mdl_fwd_b", c, int'(fb2), eb);
        chk("mdl_stall", c, int'(st2), int'(est));
        chk("mdl_stall_count", c, int'(cnt2), mcnt[c]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic ins(int v, int r1, int u1, int r2, int u2, int rd, int wr, int ld);
    rst_n      = 1'b1;
    flush      = 1'b0;
    hold       = 1'b0;
    id_valid   = (v != 0);
    id_rs1     = 3'(r1);
    id_use_rs1 = (u1 != 0);
    id_rs2     = 3'(r2);
    id_use_rs2 = (u2 != 0);
    id_rd      = 3'(rd);
    id_regwr   = (wr != 0);
    id_memrd   = (ld != 0);
  endtask

  // Directed vectors for the default configuration (NUM_FWD=3, LOAD_LAT=1).
  typedef struct {
    int rst, vld, fl, hd;
    int rs1, u1, rs2, u2;
    int rd, wr, ld;
    int fa, fb, st, cnt;
  } vec_t;
  localparam int NV = 25;
  vec_t tbl [NV];

  initial begin
    //            rst vld fl hd  rs1 u1 rs2 u2  rd wr ld   fa fb st cnt
    tbl[0]  = '{1, 1, 0, 0,  2, 1, 3, 1,  1, 1, 0,  0, 0, 0, 0}; // ADD r1
    tbl[1]  = '{1, 1, 0, 0,  1, 1, 3, 1,  2, 1, 0,  1, 0, 0, 0}; // ADD r2,r1,r3 -> EX fwd
    tbl[2]  = '{1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0}; // empty slot
    tbl[3]  = '{1, 1, 0, 0,  5, 1, 0, 0,  1, 1, 1,  0, 0, 0, 0}; // LW r1
    tbl[4]  = '{1, 1, 0, 0,  1, 1, 1, 1,  2, 1, 0,  0, 0, 1, 0}; // load-use stall
    tbl[5]  = '{1, 1, 0, 0,  1, 1, 1, 1,  2, 1, 0,  2, 2, 0, 1}; // then MEM fwd
    tbl[6]  = '{1, 1, 0, 0,  0, 1, 0, 1,  1, 1, 0,  0, 0, 0, 1}; // r0 sources
    tbl[7]  = '{1, 1, 0, 0,  2, 1, 0, 1,  1, 1, 0,  2, 0, 0, 1}; // ADD r1 again
    tbl[8]  = '{1, 1, 0, 0,  1, 1, 1, 1,  2, 1, 0,  1, 1, 0, 1}; // youngest wins
    tbl[9]  = '{1, 1, 0, 0,  2, 1, 1, 1,  3, 0, 0,  1, 2, 0, 1}; // store (no write)
    tbl[10] = '{1, 1, 0, 0,  3, 1, 2, 1,  0, 0, 0,  0, 2, 0, 1}; // store never forwards
    tbl[11] = '{1, 1, 0, 0,  0, 0, 0, 0,  1, 1, 1,  0, 0, 0, 1}; // LW r1
    tbl[12] = '{1, 1, 1, 0,  1, 1, 1, 1,  2, 1, 0,  0, 0, 0, 1}; // flush beats stall
    tbl[13] = '{1, 1, 0, 0,  1, 1, 1, 1,  2, 1, 0,  2, 2, 0, 1}; // bubble in s1
    tbl[14] = '{1, 1, 0, 0,  0, 0, 0, 0,  3, 1, 1,  0, 0, 0, 1}; // LW r3
    tbl[15] = '{1, 1, 0, 1,  3, 1, 0, 0,  4, 1, 0,  0, 0, 1, 1}; // hold mid-stall
    tbl[16] = '{1, 1, 0, 1,  3, 1, 0, 0,  4, 1, 0,  0, 0, 1, 1};
    tbl[17] = '{1, 1, 0, 1,  3, 1, 0, 0,  4, 1, 0,  0, 0, 1, 1};
    tbl[18] = '{1, 1, 0, 0,  3, 1, 0, 0,  4, 1, 0,  0, 0, 1, 1}; // release hold
    tbl[19] = '{1, 1, 0, 0,  3, 1, 0, 0,  4, 1, 0,  2, 0, 0, 2};
    tbl[20] = '{1, 1, 0, 0,  3, 1, 3, 1,  5, 1, 0,  3, 3, 0, 2}; // rs1 == rs2, WB fwd
    tbl[21] = '{1, 1, 0, 0,  0, 0, 0, 0,  1, 1, 1,  0, 0, 0, 2}; // LW r1
    tbl[22] = '{0, 1, 0, 1,  1, 1, 0, 0,  2, 1, 0,  0, 0, 1, 2}; // reset over hold
    tbl[23] = '{1, 1, 0, 0,  1, 1, 0, 0,  2, 1, 0,  0, 0, 0, 0}; // load forgotten
    tbl[24] = '{1, 1, 0, 0,  1, 1, 0, 0,  2, 1, 0,  0, 0, 0, 0};
  end

  initial begin
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_fwd_a", 0, int'(fa1), 0);
    chk("rst_fwd_b", 0, int'(fb1), 0);
    chk("rst_stall", 0, int'(st1), 0);
    chk("rst_stall_count", 0, int'(cnt1), 0);
    chk("rst_stall", 1, int'(st2), 0);
    chk("rst_stall_count", 1, int'(cnt2), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      ins(tbl[i].vld, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2,
          tbl[i].rd, tbl[i].wr, tbl[i].ld);
      rst_n = (tbl[i].rst != 0);
      flush = (tbl[i].fl != 0);
      hold  = (tbl[i].hd != 0);
      settle();
      chk("tbl_fwd_a", i, int'(fa1), tbl[i].fa);
      chk("tbl_fwd_b", i, int'(fb1), tbl[i].fb);
      chk("tbl_stall", i, int'(st1), tbl[i].st);
      chk("tbl_stall_count", i, int'(cnt1), tbl[i].cnt);
      tick();
    end

    // LOAD_LAT=2, NUM_FWD=4: LW r4 then SUB r5,r4,r6.
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    ins(1, 0, 0, 0, 0, 4, 1, 1);
    step();
    ins(1, 4, 1, 6, 1, 5, 1, 0);
    settle();
    chk("l2_stall", 0, int'(st2), 1);
    chk("l2_fwd_a", 0, int'(fa2), 0);
    tick();
    settle();
    chk("l2_stall", 1, int'(st2), 1);
    tick();
    settle();
    chk("l2_stall", 2, int'(st2), 0);
    chk("l2_fwd_a", 2, int'(fa2), 3);
    chk("l2_fwd_b", 2, int'(fb2), 0);
    chk("l2_stall_count", 2, int'(cnt2), 2);
    tick();

    // Drive the 3-bit counter well past its ceiling.
    for (int it = 0; it < 4; it++) begin
      ins(1, 0, 0, 0, 0, 1, 1, 1);
      step();
      ins(1, 1, 1, 0, 0, 2, 1, 0);
      repeat (3) step();
    end
    settle();
    chk("cnt_saturate", 0, int'(cnt2), 7);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      ins(($urandom_range(0, 3) != 0) ? 1 : 0,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0) ? 1 : 0,
          ($urandom_range(0, 2) == 0) ? 1 : 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
